// File: rtl/mdc_com_sched.sv
// mdc_com_sched: frame scheduler for the 32-point radix-2 MDC FFT (commutator config + output framing)
module mdc_com_sched #(
  parameter int PIPE_LAT  = 23,
  parameter int FRAME_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_sop,
  output logic       mode,
  output logic [5:0] com_mask,
  output logic [3:0] ph,
  output logic       busy,
  output logic       out_valid,
  output logic       out_sop,
  output logic       frame_done,
  output logic       err_gap,
  output logic       err_sop
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  localparam logic [3:0] LAST = 4'(FRAME_CYC - 1);
  state_t                state_q, state_d;
  logic [3:0]            ph_q, ph_d;
  logic [5:0]            fc_q, fc_d;
  logic [PIPE_LAT-1:0]   sv_q, sv_d, ss_q, ss_d;
  logic [3:0]            oc_q, oc_d, oidx;
  logic                  mode_q, mode_d;
  logic [5:0]            com_mask_q, com_mask_d;
  logic                  err_gap_q, err_gap_d, err_sop_q, err_sop_d;
  logic                  frame_done_q, frame_done_d;
  logic                  acc, acc_sop;
  // state and all registered outputs; reset discards every in-flight frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ph_q         <= '0;
      fc_q         <= '0;
      sv_q         <= '0;
      ss_q         <= '0;
      oc_q         <= '0;
      mode_q       <= 1'b1;
      com_mask_q   <= '0;
      err_gap_q    <= 1'b0;
      err_sop_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      fc_q         <= fc_d;
      sv_q         <= sv_d;
      ss_q         <= ss_d;
      oc_q         <= oc_d;
      mode_q       <= mode_d;
      com_mask_q   <= com_mask_d;
      err_gap_q    <= err_gap_d;
      err_sop_q    <= err_sop_d;
      frame_done_q <= frame_done_d;
    end
  end
  // next state: ph_q is the phase of the last processed pair, so ph_q==LAST marks a frame boundary
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q + 4'd1;
    fc_d      = fc_q;
    acc       = 1'b0;
    acc_sop   = 1'b0;
    err_gap_d = 1'b0;
    err_sop_d = 1'b0;
    case (state_q)
      IDLE: begin
        ph_d = 4'd0;
        if (in_valid && in_sop) begin
          state_d = FILL;
          acc     = 1'b1;
          acc_sop = 1'b1;
        end
      end
      FILL, RUN: begin
        if (ph_q == LAST) begin
          if (in_valid && in_sop) begin
            state_d = RUN;
            ph_d    = 4'd0;
            acc     = 1'b1;
            acc_sop = 1'b1;
          end else begin
            state_d   = FLUSH;
            fc_d      = 6'd1;
            err_gap_d = in_valid;
          end
        end else if (!in_valid) begin
          state_d   = FLUSH;
          fc_d      = 6'd1;
          err_gap_d = 1'b1;
        end else if (in_sop) begin
          state_d   = RUN;
          ph_d      = 4'd0;
          acc       = 1'b1;
          acc_sop   = 1'b1;
          err_sop_d = 1'b1;
        end else begin
          acc = 1'b1;
        end
      end
      default: begin
        if (in_valid && in_sop) begin
          state_d = RUN;
          ph_d    = 4'd0;
          fc_d    = 6'd0;
          acc     = 1'b1;
          acc_sop = 1'b1;
        end else if (({1'b0, fc_q} + 7'd1) >= 7'(PIPE_LAT)) begin
          state_d = IDLE;
          ph_d    = 4'd0;
          fc_d    = 6'd0;
        end else begin
          fc_d = fc_q + 6'd1;
        end
      end
    endcase
  end
  // outputs: commutator config for the pair just taken, plus delayed framing and output pair index
  always_comb begin
    mode_d       = state_d != RUN;
    com_mask_d   = (state_d == IDLE) ? 6'd0 :
                   {ph_d[1:0] == 2'b11, ph_d[1:0] == 2'b10, ~ph_d[1], ph_d[2], ~ph_d[2], ph_d[3]};
    sv_d         = (sv_q << 1) | PIPE_LAT'(acc);
    ss_d         = (ss_q << 1) | PIPE_LAT'(acc_sop);
    oidx         = ss_d[PIPE_LAT-1] ? 4'd0 : oc_q + 4'd1;
    oc_d         = sv_d[PIPE_LAT-1] ? oidx : oc_q;
    frame_done_d = sv_d[PIPE_LAT-1] && (oidx == LAST);
  end
  assign mode       = mode_q;
  assign com_mask   = com_mask_q;
  assign ph         = ph_q;
  assign busy       = state_q != IDLE;
  assign out_valid  = sv_q[PIPE_LAT-1];
  assign out_sop    = ss_q[PIPE_LAT-1];
  assign frame_done = frame_done_q;
  assign err_gap    = err_gap_q;
  assign err_sop    = err_sop_q;
endmodule

// File: tb/tb_mdc_com_sched.sv
// tb_mdc_com_sched: directed scenarios with an output-framing scoreboard for mdc_com_sched
module tb_mdc_com_sched;
  localparam int LAT = 23;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic       mode, busy, out_valid, out_sop, frame_done, err_gap, err_sop;
  logic [5:0] com_mask;
  logic [3:0] ph;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  typedef struct {int t; bit sop; bit done;} exp_t;
  exp_t q[$];
  exp_t me;

  mdc_com_sched #(.PIPE_LAT(LAT), .FRAME_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .mode(mode), .com_mask(com_mask), .ph(ph), .busy(busy),
    .out_valid(out_valid), .out_sop(out_sop), .frame_done(frame_done),
    .err_gap(err_gap), .err_sop(err_sop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [5:0] cm(input logic [3:0] p);
    return {p[1:0] == 2'b11, p[1:0] == 2'b10, ~p[1], p[2], ~p[2], p[3]};
  endfunction

  // scoreboard: every output pair must match the oldest expected pair, at its expected cycle
  always @(negedge clk) if (rst_n) begin
    if (out_valid) begin
      if (q.size() == 0) chk("out_extra", {31'b0, out_valid}, 0);
      else begin
        me = q.pop_front();
        chk("out_cycle", cyc, me.t);
        chk("out_sop", {31'b0, out_sop}, {31'b0, me.sop});
        chk("frame_done", {31'b0, frame_done}, {31'b0, me.done});
      end
    end else if (q.size() > 0 && q[0].t <= cyc) begin
      me = q.pop_front();
      chk("out_missing", {31'b0, out_valid}, 1);
    end
  end

  // n pairs, sop on the first; es0 expects err_sop on that first pair
  task automatic send_frame(input int n, input bit exp_mode, input bit es0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sop   = (i == 0);
      q.push_back('{cyc + LAT, i == 0, i == 15});
      @(posedge clk); #1;
      chk("ph", ph, i);
      chk("com_mask", com_mask, cm(4'(i)));
      chk("mode", mode, exp_mode);
      chk("err_sop", err_sop, (i == 0) && es0);
      chk("err_gap", err_gap, 0);
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    int k;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    t = cyc;
    if (k == 200) chk("idle_timeout", {31'b0, busy}, 0);
  endtask

  initial begin
    int t0, t1;
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", mode, 1);
    chk("rst_mask", com_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_ph", ph, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // single frame, p=15 mask is 6'b100101
    t0 = cyc;
    send_frame(16, 1'b1, 1'b0);
    chk("mask_p15", com_mask, 6'b100101);
    wait_idle(t1);
    chk("busy_drop", t1 - t0, 39);
    // three back-to-back frames
    send_frame(16, 1'b1, 1'b0);
    send_frame(16, 1'b0, 1'b0);
    send_frame(16, 1'b0, 1'b0);
    wait_idle(t1);
    // mid-frame gap at ph=5
    send_frame(5, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("gap_err", err_gap, 1);
    chk("gap_busy", busy, 1);
    chk("gap_mode", mode, 1);
    @(posedge clk); #1;
    chk("gap_pulse", err_gap, 0);
    wait_idle(t1);
    // valid without sop at a frame boundary, then ignored during flush
    send_frame(16, 1'b1, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bnd_gap_err", err_gap, 1);
    chk("bnd_gap_mode", mode, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bnd_gap_pulse", err_gap, 0);
      chk("flush_busy", busy, 1);
    end
    wait_idle(t1);
    // early sop at ph=9
    send_frame(9, 1'b1, 1'b0);
    send_frame(16, 1'b0, 1'b1);
    wait_idle(t1);
    // new sop during flush, 8 cycles after the frame end
    send_frame(16, 1'b1, 1'b0);
    repeat (8) begin
      @(posedge clk); #1;
      chk("fl_busy", busy, 1);
      chk("fl_mode", mode, 1);
      chk("fl_gap", err_gap, 0);
    end
    send_frame(16, 1'b0, 1'b0);
    wait_idle(t1);
    // idle valid without sop is ignored
    in_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_nosop_busy", busy, 0);
    end
    in_valid = 1'b0;
    // async reset at ph=7 of RUN
    send_frame(16, 1'b1, 1'b0);
    send_frame(8, 1'b0, 1'b0);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("ar_mode", mode, 1);
    chk("ar_mask", com_mask, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ovalid", out_valid, 0);
    chk("ar_osop", out_sop, 0);
    chk("ar_done", frame_done, 0);
    chk("ar_ph", ph, 0);
    chk("ar_errs", {err_gap, err_sop}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ovalid", out_valid, 0);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
